// File: rtl/rr_mux8to1.sv
// Purpose: gathers eight valid/ready channels onto one registered output, tagging each word with its source index on Sel.
// Latency: one cycle from input acceptance to Out_Valid/Out_Data/Sel.
// Backpressure: when Out_Valid=1 and Out_Ready=0, every In_Ready bit is 0 and all outputs hold.
module rr_mux8to1 #(
  parameter int WIDTH = 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [8*WIDTH-1:0] In_Data,
  input  logic [7:0]         In_Valid,
  output logic [7:0]         In_Ready,
  output logic [WIDTH-1:0]   Out_Data,
  output logic [2:0]         Sel,
  output logic               Out_Valid,
  input  logic               Out_Ready
);

  // Ptr is the first channel the next search starts from.
  logic [2:0]       ptr;
  logic             load;
  logic             grant_vld;
  logic [2:0]       grant_idx;
  logic [WIDTH-1:0] grant_dat;
  logic             take;

  // The output register can take a new word when it is empty or being drained this cycle.
  assign load = ~Out_Valid | Out_Ready;

  // Round-robin search from ptr. The scan runs from the farthest offset down to 0, so the
  // nearest valid channel overwrites the others and wins.
  always_comb begin
    logic [2:0] idx;
    grant_vld = 1'b0;
    grant_idx = 3'd0;
    idx       = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (In_Valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // A grant is only issued when the output register can take a word. In_Ready is also gated
  // by reset so no transfer is signalled while the block is held in reset.
  assign take      = load & grant_vld & Rst_n;
  assign In_Ready  = take ? (8'b0000_0001 << grant_idx) : 8'b0000_0000;
  assign grant_dat = In_Data[int'(grant_idx)*WIDTH +: WIDTH];

  // The output register and pointer advance on a grant. Otherwise a consumed word clears Out_Valid.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Sel       <= 3'd0;
      ptr       <= 3'd0;
    end else if (take) begin
      Out_Valid <= 1'b1;
      Out_Data  <= grant_dat;
      Sel       <= grant_idx;
      ptr       <= grant_idx + 3'd1;
    end else if (Out_Valid && Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule
